quiz_controller: RTL and testbench
==================================

QUIZ_CONTROLLER -- requirements
Module: quiz_controller

Interface
REQ-001 Parameter NUM_Q, default 9, number of questions per round (1..15).
REQ-002 Parameter TIMEOUT, default 1000, clock cycles allowed per answer (>=2).
REQ-003 Parameter FB_CYCLES, default 50, cycles the verdict is held for display (>=1).
REQ-004 Design SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  single-cycle pulse; begins a round.
REQ-008 ans_valid  in  1  answer offered this cycle.
REQ-009 ans  in  8  player answer, unsigned.
REQ-010 ans_ready  out  1  controller accepts ans this cycle.
REQ-011 q_left  in  4  left operand from the question source for q_index.
REQ-012 q_right  in  4  right operand from the question source for q_index.
REQ-013 q_op  in  4  one-hot operator: 4'b0001 add, 4'b0010 sub, 4'b0100 mul, 4'b1000 div.
REQ-014 q_index  out  4  current question number driven to the question source.
REQ-015 score  out  4  count of correct answers this round.
REQ-016 correct  out  1  high during FEEDBACK when the last answer matched.
REQ-017 wrong  out  1  high during FEEDBACK when the last answer mismatched or timed out.
REQ-018 timed_out  out  1  high during FEEDBACK when no answer arrived in time.
REQ-019 busy  out  1  high in every state except IDLE and DONE.
REQ-020 done  out  1  high in DONE.

Function
REQ-021 States SHALL be IDLE, LOAD, WAIT_ANS, CHECK, FEEDBACK, DONE.
REQ-022 IDLE: start -> LOAD with q_index=0, score=0.
REQ-023 LOAD (1 cycle): latch q_left/q_right/q_op into internal operand registers; -> WAIT_ANS with timer cleared.
REQ-024 WAIT_ANS: ans_ready=1; ans_valid=1 -> latch ans, -> CHECK; else timer increments; timer reaching TIMEOUT-1 without ans_valid -> FEEDBACK with wrong=1, timed_out=1.
REQ-025 ans_valid and timer expiry in the same cycle: the answer SHALL win (-> CHECK).
REQ-026 ans_ready SHALL be 0 in every state except WAIT_ANS; ans_valid outside WAIT_ANS is ignored.
REQ-027 CHECK SHALL last exactly 4 cycles for every operator, so the verdict appears 5 cycles after answer acceptance.
REQ-028 Expected value width is 8 bits: add = left+right; mul = left*right; sub = left-right if left>=right, else 8'hFF.
REQ-029 div = integer quotient via 4-cycle restoring divider in CHECK; right=0 SHALL give 8'hFF.
REQ-030 q_op not one-hot (including 0) SHALL give expected 8'hFF.
REQ-031 Compare: ans==expected and expected!=8'hFF -> correct=1, score+1; otherwise wrong=1.
REQ-032 FEEDBACK SHALL hold correct/wrong/timed_out stable for FB_CYCLES cycles, then clear them.
REQ-033 FEEDBACK exit: q_index==NUM_Q-1 -> DONE; else q_index+1, -> LOAD.
REQ-034 Score SHALL saturate at 15.
REQ-035 DONE: score and q_index held; start -> LOAD with q_index=0, score=0.
REQ-036 start in any state other than IDLE or DONE SHALL be ignored.

Reset
REQ-037 rst_n low SHALL immediately force IDLE; q_index=0, score=0, timer=0, internal operand and answer registers=0.
REQ-038 Reset outputs: ans_ready=0, correct=0, wrong=0, timed_out=0, busy=0, done=0.
REQ-039 Reset asserted mid-CHECK or mid-FEEDBACK SHALL abort with no score update.

Verification
REQ-040 Idx0 8,2,1000; ans=4 -> 5 cycles after accept: correct=1, score=1, held FB_CYCLES; then q_index=1.
REQ-041 Idx1 2,3,0100; ans=5 -> wrong=1, timed_out=0, score unchanged.
REQ-042 WAIT_ANS with no ans_valid for TIMEOUT cycles -> wrong=1, timed_out=1; ans_valid at the expiry cycle -> CHECK instead.
REQ-043 Div by zero: 7,0,1000 with ans=255 -> wrong=1; q_op=4'b0011 -> wrong=1.
REQ-044 NUM_Q=9, questions (8/2,2*3,9-2,5+3,4+5,9/3,6+3,1/1,6-4), all answers correct -> score=9, done=1, busy=0; start -> score=0, q_index=0.
REQ-045 rst_n low in 2nd CHECK cycle -> IDLE next edge, score=0, all verdict outputs 0.

Source files
------------

// File: rtl/quiz_controller.sv
// Arithmetic quiz round sequencer: loads a question, waits for an answer, checks it, shows the verdict.
// Latency: verdict 5 cycles after answer acceptance (4-cycle CHECK for all operators).
// Backpressure: ans_ready high only in WAIT_ANS; answers offered in any other state are dropped.
module quiz_controller #(
    parameter int unsigned NUM_Q     = 9,
    parameter int unsigned TIMEOUT   = 1000,
    parameter int unsigned FB_CYCLES = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       ans_valid,
    input  logic [7:0] ans,
    output logic       ans_ready,
    input  logic [3:0] q_left,
    input  logic [3:0] q_right,
    input  logic [3:0] q_op,
    output logic [3:0] q_index,
    output logic [3:0] score,
    output logic       correct,
    output logic       wrong,
    output logic       timed_out,
    output logic       busy,
    output logic       done
);
    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam int unsigned FW = $clog2(FB_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [FW-1:0] F_LAST = FW'(FB_CYCLES - 1);
    localparam logic [3:0]    Q_LAST = 4'(NUM_Q - 1);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT_ANS, CHECK, FEEDBACK, DONE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    opl_q, opl_d, opr_q, opr_d, op_q, op_d;
    logic [7:0]    ans_q, ans_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    chk_cnt_q, chk_cnt_d;
    logic [FW-1:0] fb_cnt_q, fb_cnt_d;
    logic [3:0]    rem_q, rem_d, quo_q, quo_d;
    logic [3:0]    q_index_q, q_index_d, score_q, score_d;
    logic          correct_q, correct_d, wrong_q, wrong_d, timed_out_q, timed_out_d;

    // One restoring-division step: quo_q shifts the dividend out MSB-first and the quotient in.
    logic [4:0] div_tmp, div_diff;
    logic       div_ge;
    logic [3:0] div_rem_nx, div_quo_nx;
    logic [7:0] expected;
    logic       match;

    always_comb begin
        div_tmp    = {rem_q, quo_q[3]};
        div_diff   = div_tmp - {1'b0, opr_q};
        div_ge     = (div_tmp >= {1'b0, opr_q});
        div_rem_nx = div_ge ? div_diff[3:0] : div_tmp[3:0];
        div_quo_nx = {quo_q[2:0], div_ge};
    end

    // 8'hFF doubles as the "no valid answer" marker, so it can never score.
    always_comb begin
        expected = 8'hFF;
        case (op_q)
            4'b0001: expected = {4'b0, opl_q} + {4'b0, opr_q};
            4'b0010: expected = (opl_q >= opr_q) ? {4'b0, opl_q - opr_q} : 8'hFF;
            4'b0100: expected = {4'b0, opl_q} * {4'b0, opr_q};
            4'b1000: expected = (opr_q == 4'd0) ? 8'hFF : {4'b0, div_quo_nx};
            default: expected = 8'hFF;
        endcase
        match = (ans_q == expected) && (expected != 8'hFF);
    end

    always_comb begin
        state_d     = state_q;
        opl_d       = opl_q;
        opr_d       = opr_q;
        op_d        = op_q;
        ans_d       = ans_q;
        timer_d     = timer_q;
        chk_cnt_d   = chk_cnt_q;
        fb_cnt_d    = fb_cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        q_index_d   = q_index_q;
        score_d     = score_q;
        correct_d   = correct_q;
        wrong_d     = wrong_q;
        timed_out_d = timed_out_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    q_index_d = 4'd0;
                    score_d   = 4'd0;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                opl_d   = q_left;
                opr_d   = q_right;
                op_d    = q_op;
                rem_d   = 4'd0;
                quo_d   = q_left;
                timer_d = '0;
                state_d = WAIT_ANS;
            end
            WAIT_ANS: begin
                if (ans_valid) begin
                    ans_d     = ans;
                    chk_cnt_d = 2'd0;
                    state_d   = CHECK;
                end else if (timer_q == T_LAST) begin
                    wrong_d     = 1'b1;
                    timed_out_d = 1'b1;
                    fb_cnt_d    = '0;
                    state_d     = FEEDBACK;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            CHECK: begin
                rem_d = div_rem_nx;
                quo_d = div_quo_nx;
                if (chk_cnt_q == 2'd3) begin
                    correct_d = match;
                    wrong_d   = !match;
                    if (match && score_q != 4'hF) score_d = score_q + 4'd1;
                    fb_cnt_d  = '0;
                    state_d   = FEEDBACK;
                end else begin
                    chk_cnt_d = chk_cnt_q + 2'd1;
                end
            end
            FEEDBACK: begin
                if (fb_cnt_q == F_LAST) begin
                    correct_d   = 1'b0;
                    wrong_d     = 1'b0;
                    timed_out_d = 1'b0;
                    if (q_index_q == Q_LAST) begin
                        state_d = DONE;
                    end else begin
                        q_index_d = q_index_q + 4'd1;
                        state_d   = LOAD;
                    end
                end else begin
                    fb_cnt_d = fb_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            opl_q       <= '0;
            opr_q       <= '0;
            op_q        <= '0;
            ans_q       <= '0;
            timer_q     <= '0;
            chk_cnt_q   <= '0;
            fb_cnt_q    <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            q_index_q   <= '0;
            score_q     <= '0;
            correct_q   <= 1'b0;
            wrong_q     <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            opl_q       <= opl_d;
            opr_q       <= opr_d;
            op_q        <= op_d;
            ans_q       <= ans_d;
            timer_q     <= timer_d;
            chk_cnt_q   <= chk_cnt_d;
            fb_cnt_q    <= fb_cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            q_index_q   <= q_index_d;
            score_q     <= score_d;
            correct_q   <= correct_d;
            wrong_q     <= wrong_d;
            timed_out_q <= timed_out_d;
        end
    end

    assign ans_ready = (state_q == WAIT_ANS);
    assign busy      = (state_q != IDLE) && (state_q != DONE);
    assign done      = (state_q == DONE);
    assign q_index   = q_index_q;
    assign score     = score_q;
    assign correct   = correct_q;
    assign wrong     = wrong_q;
    assign timed_out = timed_out_q;
endmodule

// File: tb/tb_quiz_controller.sv
// Directed bench for quiz_controller: two full rounds from hand-built question tables plus a mid-CHECK reset.
// Inputs driven and outputs sampled on the falling edge.
module tb_quiz_controller;
    localparam int NQ = 9;
    localparam int TO = 16;
    localparam int FB = 6;

    logic       clk, rst_n, start, ans_valid, ans_ready;
    logic [7:0] ans;
    logic [3:0] q_left, q_right, q_op, q_index, score;
    logic       correct, wrong, timed_out, busy, done;

    logic [3:0] tl [16];
    logic [3:0] tr [16];
    logic [3:0] top[16];

    int errs   = 0;
    int checks = 0;

    quiz_controller #(.NUM_Q(NQ), .TIMEOUT(TO), .FB_CYCLES(FB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ans_valid(ans_valid), .ans(ans),
        .ans_ready(ans_ready), .q_left(q_left), .q_right(q_right), .q_op(q_op),
        .q_index(q_index), .score(score), .correct(correct), .wrong(wrong),
        .timed_out(timed_out), .busy(busy), .done(done)
    );

    assign q_left  = tl[q_index];
    assign q_right = tr[q_index];
    assign q_op    = top[q_index];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!ans_ready && n < 3 * TO) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rdy"}, ans_ready, 1);
    endtask

    task automatic start_round(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_idx"}, q_index, 0);
        chk({tag, "_score"}, score, 0);
        chk({tag, "_load_rdy"}, ans_ready, 0);
    endtask

    // One question: answer after dly idle WAIT_ANS cycles (or let it time out), then walk the verdict window.
    task automatic do_q(input string tag, input logic [7:0] a, input int dly, input bit to,
                        input bit ok, input logic [3:0] exp_score, input logic [3:0] exp_idx,
                        input bit last);
        wait_ready(tag);
        if (to) begin
            repeat (TO - 1) @(negedge clk);
            chk({tag, "_still_rdy"}, ans_ready, 1);
            @(negedge clk);
        end else begin
            repeat (dly) @(negedge clk);
            ans       = a;
            ans_valid = 1'b1;
            @(negedge clk);
            ans = ~a;
            chk({tag, "_chk_rdy"}, ans_ready, 0);
            repeat (3) @(negedge clk);
            chk({tag, "_early"}, {correct, wrong}, 0);
            ans_valid = 1'b0;
            @(negedge clk);
        end
        chk({tag, "_correct"}, correct, ok);
        chk({tag, "_wrong"}, wrong, !ok);
        chk({tag, "_to"}, timed_out, to);
        chk({tag, "_score"}, score, exp_score);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (FB - 2) @(negedge clk);
        chk({tag, "_hold"}, {correct, wrong, timed_out}, {ok, !ok, to});
        @(negedge clk);
        chk({tag, "_clr"}, {correct, wrong, timed_out}, 0);
        chk({tag, "_nidx"}, q_index, exp_idx);
        chk({tag, "_ndone"}, {done, busy}, last ? 2'b10 : 2'b01);
    endtask

    logic [7:0] a_ans[NQ] = '{8'd4, 8'd5, 8'd0, 8'd8, 8'd255, 8'd255, 8'd255, 8'd225, 8'd3};
    bit         a_to [NQ] = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
    bit         a_ok [NQ] = '{1, 0, 0, 1, 0, 0, 0, 1, 1};
    int         a_dly[NQ] = '{0, 2, 0, TO - 1, 1, 0, 3, 0, 5};
    logic [3:0] a_sc [NQ] = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd3, 4'd4};
    logic [7:0] b_ans[NQ] = '{8'd4, 8'd6, 8'd7, 8'd8, 8'd9, 8'd3, 8'd9, 8'd1, 8'd2};

    initial begin
        rst_n = 1'b0; start = 1'b0; ans_valid = 1'b0; ans = 8'd0;
        for (int i = 0; i < 16; i++) begin
            tl[i] = 4'd0; tr[i] = 4'd0; top[i] = 4'd0;
        end
        // Round A: mixed verdicts, timeout, expiry-cycle answer, div by zero, bad op, sub underflow.
        tl[0] = 4'd8;  tr[0] = 4'd2;  top[0] = 4'b1000;
        tl[1] = 4'd2;  tr[1] = 4'd3;  top[1] = 4'b0100;
        tl[2] = 4'd9;  tr[2] = 4'd2;  top[2] = 4'b0010;
        tl[3] = 4'd5;  tr[3] = 4'd3;  top[3] = 4'b0001;
        tl[4] = 4'd7;  tr[4] = 4'd0;  top[4] = 4'b1000;
        tl[5] = 4'd3;  tr[5] = 4'd1;  top[5] = 4'b0011;
        tl[6] = 4'd2;  tr[6] = 4'd5;  top[6] = 4'b0010;
        tl[7] = 4'd15; tr[7] = 4'd15; top[7] = 4'b0100;
        tl[8] = 4'd15; tr[8] = 4'd4;  top[8] = 4'b1000;

        repeat (2) @(negedge clk);
        chk("rst_out", {ans_ready, correct, wrong, timed_out, busy, done}, 0);
        chk("rst_cnt", {q_index, score}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        start_round("A_start");
        for (int i = 0; i < NQ; i++)
            do_q($sformatf("A%0d", i), a_ans[i], a_dly[i], a_to[i], a_ok[i], a_sc[i],
                 (i == NQ - 1) ? 4'(NQ - 1) : 4'(i + 1), i == NQ - 1);
        repeat (3) @(negedge clk);
        chk("A_done_hold", {done, busy, score, q_index}, {1'b1, 1'b0, 4'd4, 4'd8});

        // Round B: the all-correct nine-question round.
        tl[0] = 4'd8; tr[0] = 4'd2; top[0] = 4'b1000;
        tl[1] = 4'd2; tr[1] = 4'd3; top[1] = 4'b0100;
        tl[2] = 4'd9; tr[2] = 4'd2; top[2] = 4'b0010;
        tl[3] = 4'd5; tr[3] = 4'd3; top[3] = 4'b0001;
        tl[4] = 4'd4; tr[4] = 4'd5; top[4] = 4'b0001;
        tl[5] = 4'd9; tr[5] = 4'd3; top[5] = 4'b1000;
        tl[6] = 4'd6; tr[6] = 4'd3; top[6] = 4'b0001;
        tl[7] = 4'd1; tr[7] = 4'd1; top[7] = 4'b1000;
        tl[8] = 4'd6; tr[8] = 4'd4; top[8] = 4'b0010;
        start_round("B_start");
        for (int i = 0; i < NQ; i++)
            do_q($sformatf("B%0d", i), b_ans[i], i % 3, 1'b0, 1'b1, 4'(i + 1),
                 (i == NQ - 1) ? 4'(NQ - 1) : 4'(i + 1), i == NQ - 1);
        chk("B_final", {done, busy, score}, {1'b1, 1'b0, 4'd9});

        // Round C: one correct answer, then reset during the second CHECK cycle of question 1.
        start_round("C_start");
        do_q("C0", 8'd4, 0, 1'b0, 1'b1, 4'd1, 4'd1, 1'b0);
        wait_ready("C1");
        ans       = 8'd6;
        ans_valid = 1'b1;
        @(negedge clk);
        ans_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("C_rst_out", {ans_ready, correct, wrong, timed_out, busy, done}, 0);
        chk("C_rst_cnt", {q_index, score}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("C_idle", {busy, done, score}, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
